// File: rtl/jk_reg_bank.sv
// Bank of WIDTH independent JK/D/T/SR flip-flops that share one mode select.
// Optional build macro: JK_REG_BANK_TOGGLE_CNT_EN adds the toggle_cnt counter and port.

module jk_reg_bank_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       sync_clr,
  input  logic [1:0] mode,
  input  logic       j,
  input  logic       k,
  output logic       q,
  output logic       q_nxt
);
  always_comb begin
    q_nxt = q;
    if (sync_clr) q_nxt = RST_BIT;
    else if (en) begin
      unique case (mode)
        2'b00: q_nxt = (j & ~q) | (~k & q);
        2'b01: q_nxt = j;
        2'b10: q_nxt = j ^ q;
        2'b11: q_nxt = (j & ~k) ? 1'b1 : ((~j & k) ? 1'b0 : q);
        default: q_nxt = q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset)
    if (!reset) q <= RST_BIT;
    else        q <= q_nxt;
endmodule

module jk_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             sync_clr,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] j,
  input  logic [WIDTH-1:0] k,
  input  logic             clr_err,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar,
  output logic             changed,
  output logic             sr_err
`ifdef JK_REG_BANK_TOGGLE_CNT_EN
  , output logic [CNT_W-1:0] toggle_cnt
`endif
);
  logic [WIDTH-1:0] q_nxt;
  logic             chg_d;
  logic             err_set;

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    jk_reg_bank_cell #(.RST_BIT(RESET_VAL[i])) u_cell (
      .clk      (clk),
      .reset    (reset),
      .en       (en),
      .sync_clr (sync_clr),
      .mode     (mode),
      .j        (j[i]),
      .k        (k[i]),
      .q        (q[i]),
      .q_nxt    (q_nxt[i])
    );
  end

  // qbar is derived from the same flops, so it cannot drift from ~q.
  assign qbar    = ~q;
  assign chg_d   = |(q_nxt ^ q);
  assign err_set = en & ~sync_clr & (mode == 2'b11) & |(j & k);

  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      changed <= 1'b0;
      sr_err  <= 1'b0;
    end else begin
      changed <= chg_d;
      sr_err  <= err_set | (sr_err & ~clr_err);
    end

`ifdef JK_REG_BANK_TOGGLE_CNT_EN
  // A sync_clr that leaves q untouched zeroes the count; one that changes q counts as a change.
  always_ff @(posedge clk or negedge reset)
    if (!reset)                   toggle_cnt <= '0;
    else if (chg_d)               toggle_cnt <= toggle_cnt + 1'b1;
    else if (sync_clr)            toggle_cnt <= '0;
`endif
endmodule

// File: tb/tb_jk_reg_bank.sv
// Directed self-checking bench for jk_reg_bank (WIDTH=8, RESET_VAL=0).
module tb_jk_reg_bank;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0, sync_clr = 1'b0, clr_err = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] j = '0, k = '0;
  logic [7:0] q, qbar;
  logic       changed, sr_err;
  int         n_pass = 0, n_tot = 0;
`ifdef JK_REG_BANK_TOGGLE_CNT_EN
  logic [15:0] toggle_cnt, cnt0;
  logic        en2 = 1'b0;
  logic [7:0]  j2 = '0;
  logic [7:0]  q2, qbar2;
  logic        changed2, sr_err2;
  logic [1:0]  toggle_cnt2;
`endif

  always #5 clk = ~clk;

  jk_reg_bank dut (
    .clk(clk), .reset(reset), .en(en), .sync_clr(sync_clr), .mode(mode),
    .j(j), .k(k), .clr_err(clr_err), .q(q), .qbar(qbar),
    .changed(changed), .sr_err(sr_err)
`ifdef JK_REG_BANK_TOGGLE_CNT_EN
    , .toggle_cnt(toggle_cnt)
`endif
  );

`ifdef JK_REG_BANK_TOGGLE_CNT_EN
  jk_reg_bank #(.CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .en(en2), .sync_clr(1'b0), .mode(2'b01),
    .j(j2), .k(8'h00), .clr_err(1'b0), .q(q2), .qbar(qbar2),
    .changed(changed2), .sr_err(sr_err2), .toggle_cnt(toggle_cnt2)
  );
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // asynchronous reset with no clock edge
    #1 reset = 1'b0;
    #1;
    check("rst_q", q, 8'h00);
    check("rst_qbar", qbar, 8'hFF);
    check("rst_err", sr_err, 0);
    check("rst_chg", changed, 0);
`ifdef JK_REG_BANK_TOGGLE_CNT_EN
    check("rst_cnt", toggle_cnt, 0);
`endif
    #1 reset = 1'b1;
    repeat (3) begin
      step();
      check("hold_q", q, 8'h00);
      check("hold_chg", changed, 0);
    end

    // D load to 0F, then JK
    en = 1'b1; mode = 2'b01; j = 8'h0F;
    step();
    check("d_q", q, 8'h0F);
    check("d_chg", changed, 1);
    mode = 2'b00; j = 8'hF0; k = 8'h3C;
    step();
    check("jk_q", q, 8'hF3);
    check("jk_qbar", qbar, 8'h0C);
    check("jk_chg", changed, 1);
    en = 1'b0;
    step();
    check("en0_q", q, 8'hF3);
    check("en0_chg", changed, 0);

    // sync_clr while disabled
    sync_clr = 1'b1;
    step();
    check("sclr_q", q, 8'h00);
    check("sclr_chg", changed, 1);
    sync_clr = 1'b0;

    // T mode toggles
`ifdef JK_REG_BANK_TOGGLE_CNT_EN
    cnt0 = toggle_cnt;
`endif
    en = 1'b1; mode = 2'b10; j = 8'hFF;
    step();
    check("t1_q", q, 8'hFF);
    step();
    check("t2_q", q, 8'h00);
    check("t2_qbar", qbar, 8'hFF);
`ifdef JK_REG_BANK_TOGGLE_CNT_EN
    check("t_cnt", toggle_cnt, cnt0 + 16'd2);
`endif

    // SR illegal pattern and sticky error
    mode = 2'b11; j = 8'h01; k = 8'h01;
    step();
    check("sr11_q", q, 8'h00);
    check("sr11_err", sr_err, 1);
    check("sr11_chg", changed, 0);
    clr_err = 1'b1;
    step();
    check("sr_setwins", sr_err, 1);
    mode = 2'b00; j = 8'h00; k = 8'h00;
    step();
    check("sr_clr", sr_err, 0);
    clr_err = 1'b0;

    // SR set / clear / hold-on-11
    mode = 2'b11; j = 8'h81; k = 8'h10;
    step();
    check("sr_set", q, 8'h81);
    j = 8'h00; k = 8'h01;
    step();
    check("sr_reset", q, 8'h80);
    check("sr_noerr", sr_err, 0);
    j = 8'h80; k = 8'h80;
    step();
    check("sr_hold11", q, 8'h80);
    check("sr_err2", sr_err, 1);
    en = 1'b0; clr_err = 1'b1;
    step();
    check("clr_en0", sr_err, 0);
    clr_err = 1'b0;

    // D mode with sync_clr overriding
    en = 1'b1; mode = 2'b01; j = 8'hA5; sync_clr = 1'b1;
    step();
    check("dclr_q", q, 8'h00);
    sync_clr = 1'b0;
    step();
    check("d_a5", q, 8'hA5);
    check("d_a5_qbar", qbar, 8'h5A);

    // sync_clr with q already at RESET_VAL: no change, counter cleared
    sync_clr = 1'b1;
    step();
    step();
    check("sclr_same_chg", changed, 0);
`ifdef JK_REG_BANK_TOGGLE_CNT_EN
    check("sclr_same_cnt", toggle_cnt, 0);
`endif
    sync_clr = 1'b0; j = 8'hA5;
    step();
    check("d_a5b", q, 8'hA5);

    // mid-stream async reset
    j = 8'h5A;
    #2 reset = 1'b0;
    #1;
    check("mid_rst_q", q, 8'h00);
    check("mid_rst_chg", changed, 0);
    #1 reset = 1'b1;
    step();
    check("post_rst_q", q, 8'h5A);
    check("post_rst_chg", changed, 1);

`ifdef JK_REG_BANK_TOGGLE_CNT_EN
    // 2-bit counter wraps after 4 changes
    en2 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      j2 = (i % 2 == 0) ? 8'h33 : 8'hCC;
      step();
    end
    en2 = 1'b0;
    check("cnt_wrap", toggle_cnt2, 2'd1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
